instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Requester side of the instruction-memory interface. Owns the program counter, drives the word address into the synchronous block ROM (one-cycle registered read), and pairs each returned word with its PC. Presents a valid/stall stream to decode and absorbs the ROM's read latency with a one-entry hold buffer. Accepts branch/jump redirects from execute and squashes the in-flight fetch.

## Interface
- ADDR_W, 12: ROM address width; PC is word-addressed.
- RESET_PC, 32'h0: first PC fetched after reset.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- imem_addr  out  ADDR_W  ROM address, equals pc_q[ADDR_W-1:0].
- imem_data  in  32  ROM data; holds the word at the address sampled on the previous edge.
- stall  in  1  decode cannot accept the presented instruction this cycle.
- redirect_valid  in  1  one-cycle redirect request.
- redirect_pc  in  32  redirect target (word address).
- instr_valid  out  1  instr/instr_pc hold a valid instruction.
- instr  out  32  instruction word; 0 when instr_valid=0.
- instr_pc  out  32  PC of instr; 0 when instr_valid=0.

## Operation
- Registers: pc_q (address being driven), resp_pc_q, resp_v_q (data on imem_data is valid for resp_pc_q), state {RUN, HOLD}, hold_instr, hold_pc.
- Consume: instr_valid=1 and stall=0 at an edge.
- RUN: outputs come from imem_data/resp_pc_q gated by resp_v_q. Each edge, if not (stall and instr_valid): resp_pc_q<=pc_q, resp_v_q<=1, pc_q<=pc_q+1.
- RUN, stall=1, instr_valid=1: hold_instr<=imem_data, hold_pc<=resp_pc_q, resp_pc_q<=pc_q, resp_v_q<=1, pc_q unchanged, ->HOLD.
- HOLD: outputs come from hold regs, instr_valid=1. pc_q frozen, so the ROM keeps returning mem[resp_pc_q]. stall=0 at an edge: pc_q<=pc_q+1, ->RUN. Next cycle presents mem[resp_pc_q] with no bubble.
- stall with instr_valid=0 is ignored; fetch keeps advancing.
- redirect_valid (any state, priority over stall): pc_q<=redirect_pc, resp_v_q<=0, ->RUN, hold contents discarded. The instruction presented that cycle is not consumed.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFF->0. The ROM aliases modulo 2^ADDR_W; instr_pc is the full 32-bit value.

## Timing
- Reset (async assert): pc_q=RESET_PC, resp_v_q=0, state=RUN, hold regs 0. Outputs: imem_addr=RESET_PC[ADDR_W-1:0], instr_valid=0, instr=0, instr_pc=0.
- After reset release: first edge issues nothing new; instr_valid=1 with instr_pc=RESET_PC in the cycle after that edge. Steady state is one instruction per cycle.
- Redirect at edge k: cycle after k is a bubble (instr_valid=0). Target is valid in the cycle after edge k+1 (2-cycle penalty).
- Stall for N cycles: the same instruction is presented N+1 cycles, then sequential instructions resume back-to-back.
- Redirect and stall in the same cycle: the redirect wins, and the stalled instruction is dropped.
- Reset asserted mid-operation: all state clears immediately. In-flight ROM data is ignored because resp_v_q=0.

## Structure
- Shared package (kgp_fetch_pkg): fetch_state_t {RUN, HOLD}, PC_W=32, INSTR_W=32, NOP_INSTR=32'h0.
- One sub-module: fetch_hold_buffer. It is the single-entry capture of instr/pc with a load/select control driven by the fetch FSM.
- PC register, FSM and redirect logic live in the top module.

## Test plan
ROM model returns one-cycle-late data with mem[i]=32'hA000_0000+i.
- Reset release with RESET_PC=0, stall=0 -> instr_valid rises one cycle later, then consecutive instr_pc 0,1,2,3 with instr A0000000..A0000003.
- Stall held 3 cycles while instr_pc=5 is presented -> instr_pc=5 (A0000005) shown 4 cycles, then 6,7 back-to-back with no bubble and no skipped instruction.
- redirect_valid with redirect_pc=0x40 while instr_pc=9 -> one bubble, then 0x40, 0x41 with instr A0000040, A0000041.
- Redirect asserted during HOLD with stall=1 -> held instruction dropped, bubble, then the target word; stall ignored during the bubble.
- RESET_PC=32'hFFFF_FFFE -> instr_pc FFFFFFFE, FFFFFFFF, 0, 1, with imem_addr wrapping at 2^ADDR_W.
- reset_n pulsed low mid-stream during HOLD -> instr_valid=0 and instr=0 immediately, imem_addr=RESET_PC, and the normal restart sequence follows.

Source files
------------

// File: rtl/kgp_fetch_pkg.sv
// Shared types and widths for the instruction fetch slice.
package kgp_fetch_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

    // One instruction paired with the PC it was fetched from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_slot_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: ROM request/response, decode stream and execute redirect.
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_W = 12
);
    import kgp_fetch_pkg::*;

    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               stall;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;

    // Fetch unit side.
    modport master (
        output imem_addr,
        output instr_valid,
        output instr,
        output instr_pc,
        input  imem_data,
        input  stall,
        input  redirect_valid,
        input  redirect_pc
    );

    // ROM / decode / execute side.
    modport slave (
        input  imem_addr,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output imem_data,
        output stall,
        output redirect_valid,
        output redirect_pc
    );

endinterface

// File: rtl/instruction_fetch_unit_hold_buffer.sv
// Single-entry capture of a stalled instruction and its PC, with output select.
module fetch_hold_buffer
    import kgp_fetch_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load,
    input  logic        clear,
    input  logic        sel,
    input  logic        live_valid,
    input  fetch_slot_t live_slot,
    output logic        out_valid_c,
    output fetch_slot_t out_slot_c
);

    fetch_slot_t hold_q;

    // Capture the presented slot when decode stalls it; drop it on redirect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
        end else if (clear) begin
            hold_q <= '0;
        end else if (load) begin
            hold_q <= live_slot;
        end
    end

    // Present the held slot while selected, otherwise the live ROM slot zeroed when invalid.
    always_comb begin
        out_valid_c = 1'b0;
        out_slot_c  = '{instr: NOP_INSTR, pc: '0};
        if (sel) begin
            out_valid_c = 1'b1;
            out_slot_c  = hold_q;
        end else if (live_valid) begin
            out_valid_c = 1'b1;
            out_slot_c  = live_slot;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC, ROM addressing, stall hold and redirect squash.
module instruction_fetch_unit
    import kgp_fetch_pkg::*;
#(
    parameter int unsigned     ADDR_W   = 12,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0
)(
    input  logic                      clock,
    input  logic                      reset_n,
    instruction_fetch_unit_if.master  bus
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] resp_pc_q, resp_pc_d;
    logic            resp_v_q, resp_v_d;
    logic            hold_load;
    logic            hold_clear;
    logic            pres_valid_c;
    fetch_slot_t     live_slot;
    fetch_slot_t     pres_slot_c;

    assign live_slot = '{instr: bus.imem_data, pc: resp_pc_q};

    fetch_hold_buffer u_hold (
        .clock       (clock),
        .reset_n     (reset_n),
        .load        (hold_load),
        .clear       (hold_clear),
        .sel         (state_q == HOLD),
        .live_valid  (resp_v_q),
        .live_slot   (live_slot),
        .out_valid_c (pres_valid_c),
        .out_slot_c  (pres_slot_c)
    );

    // PC, response tag and FSM state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            resp_pc_q <= '0;
            resp_v_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            resp_v_q  <= resp_v_d;
        end
    end

    // Next-state: redirect beats stall; a stall on a valid instruction parks it in the hold buffer.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        resp_v_d   = resp_v_q;
        hold_load  = 1'b0;
        hold_clear = 1'b0;

        if (bus.redirect_valid) begin
            pc_d       = bus.redirect_pc;
            resp_v_d   = 1'b0;
            hold_clear = 1'b1;
            state_d    = RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    resp_pc_d = pc_q;
                    resp_v_d  = 1'b1;
                    if (bus.stall && pres_valid_c) begin
                        // pc_q stays put so the ROM re-reads the next word while we hold.
                        hold_load = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
                HOLD: begin
                    if (!bus.stall) begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign bus.imem_addr   = pc_q[ADDR_W-1:0];
    assign bus.instr_valid = pres_valid_c;
    assign bus.instr       = pres_slot_c.instr;
    assign bus.instr_pc    = pres_slot_c.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit against a one-cycle-latency ROM model.
module tb_instruction_fetch_unit;
    import kgp_fetch_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    logic reset_n1;
    int   vectors = 0;
    int   miscompares = 0;

    instruction_fetch_unit_if #(.ADDR_W(12)) if0 ();
    instruction_fetch_unit_if #(.ADDR_W(12)) if1 ();

    instruction_fetch_unit #(.ADDR_W(12), .RESET_PC(32'h0000_0000)) u0 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (if0.master)
    );

    instruction_fetch_unit #(.ADDR_W(12), .RESET_PC(32'hFFFF_FFFE)) u1 (
        .clock   (clock),
        .reset_n (reset_n1),
        .bus     (if1.master)
    );

    always #5 clock = ~clock;

    // ROM models: mem[i] = A000_0000 + i, registered read.
    always_ff @(posedge clock) begin
        if0.imem_data <= 32'hA000_0000 + 32'(if0.imem_addr);
        if1.imem_data <= 32'hA000_0000 + 32'(if1.imem_addr);
    end

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return 32'hA000_0000 + {20'h0, pc[11:0]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        if0.stall = 1'b0;
        if0.redirect_valid = 1'b0;
        if0.redirect_pc = 32'h0;
        tick();
        tick();
        vectors++;
        if ({if0.instr_valid, if0.instr, if0.instr_pc, if0.imem_addr} !== {1'b0, 32'h0, 32'h0, 12'h000})
            begin miscompares++; $display("FAIL reset_state: got v=%0b i=%h pc=%h a=%h want 0/0/0/000", if0.instr_valid, if0.instr, if0.instr_pc, if0.imem_addr); end
        reset_n = 1'b1;
        #1;
        vectors++;
        if (if0.instr_valid !== 1'b0)
            begin miscompares++; $display("FAIL pre_first_edge: got v=%0b want 0", if0.instr_valid); end
        tick();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({if0.instr_valid, if0.instr, if0.instr_pc} !== {1'b1, rom_word(32'(i)), 32'(i)})
                begin miscompares++; $display("FAIL startup_seq[%0d]: got v=%0b i=%h pc=%h want 1/%h/%h", i, if0.instr_valid, if0.instr, if0.instr_pc, rom_word(32'(i)), 32'(i)); end
            tick();
        end
    endtask

    task automatic test_stall();
        tick(); // presenting pc 5
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({if0.instr_valid, if0.instr, if0.instr_pc} !== {1'b1, 32'hA000_0005, 32'h5})
                begin miscompares++; $display("FAIL stall_hold[%0d]: got v=%0b i=%h pc=%h want 1/a0000005/5", i, if0.instr_valid, if0.instr, if0.instr_pc); end
            if0.stall = (i < 3);
            tick();
        end
        vectors++;
        if ({if0.instr_valid, if0.instr, if0.instr_pc} !== {1'b1, 32'hA000_0006, 32'h6})
            begin miscompares++; $display("FAIL stall_resume6: got v=%0b i=%h pc=%h want 1/a0000006/6", if0.instr_valid, if0.instr, if0.instr_pc); end
        tick();
        vectors++;
        if ({if0.instr_valid, if0.instr, if0.instr_pc} !== {1'b1, 32'hA000_0007, 32'h7})
            begin miscompares++; $display("FAIL stall_resume7: got v=%0b i=%h pc=%h want 1/a0000007/7", if0.instr_valid, if0.instr, if0.instr_pc); end
        tick(); // presenting pc 8
    endtask

    task automatic test_redirect();
        tick(); // presenting pc 9
        vectors++;
        if ({if0.instr_valid, if0.instr_pc} !== {1'b1, 32'h9})
            begin miscompares++; $display("FAIL redir_pre: got v=%0b pc=%h want 1/9", if0.instr_valid, if0.instr_pc); end
        if0.redirect_valid = 1'b1;
        if0.redirect_pc = 32'h40;
        tick();
        if0.redirect_valid = 1'b0;
        vectors++;
        if ({if0.instr_valid, if0.instr, if0.instr_pc} !== {1'b0, 32'h0, 32'h0})
            begin miscompares++; $display("FAIL redir_bubble: got v=%0b i=%h pc=%h want 0/0/0", if0.instr_valid, if0.instr, if0.instr_pc); end
        tick();
        vectors++;
        if ({if0.instr_valid, if0.instr, if0.instr_pc} !== {1'b1, 32'hA000_0040, 32'h40})
            begin miscompares++; $display("FAIL redir_target: got v=%0b i=%h pc=%h want 1/a0000040/40", if0.instr_valid, if0.instr, if0.instr_pc); end
        tick();
        vectors++;
        if ({if0.instr_valid, if0.instr, if0.instr_pc} !== {1'b1, 32'hA000_0041, 32'h41})
            begin miscompares++; $display("FAIL redir_next: got v=%0b i=%h pc=%h want 1/a0000041/41", if0.instr_valid, if0.instr, if0.instr_pc); end
    endtask

    task automatic test_redirect_in_hold();
        tick(); // presenting 0x42
        if0.stall = 1'b1;
        tick(); // holding 0x42
        vectors++;
        if ({if0.instr_valid, if0.instr, if0.instr_pc} !== {1'b1, 32'hA000_0042, 32'h42})
            begin miscompares++; $display("FAIL hold_pre_redir: got v=%0b i=%h pc=%h want 1/a0000042/42", if0.instr_valid, if0.instr, if0.instr_pc); end
        if0.redirect_valid = 1'b1;
        if0.redirect_pc = 32'h80;
        tick();
        if0.redirect_valid = 1'b0;
        vectors++;
        if ({if0.instr_valid, if0.instr, if0.instr_pc} !== {1'b0, 32'h0, 32'h0})
            begin miscompares++; $display("FAIL hold_redir_bubble: got v=%0b i=%h pc=%h want 0/0/0", if0.instr_valid, if0.instr, if0.instr_pc); end
        tick(); // stall still high, ignored during bubble
        vectors++;
        if ({if0.instr_valid, if0.instr, if0.instr_pc} !== {1'b1, 32'hA000_0080, 32'h80})
            begin miscompares++; $display("FAIL hold_redir_target: got v=%0b i=%h pc=%h want 1/a0000080/80", if0.instr_valid, if0.instr, if0.instr_pc); end
        if0.stall = 1'b0;
        tick();
        vectors++;
        if ({if0.instr_valid, if0.instr, if0.instr_pc} !== {1'b1, 32'hA000_0081, 32'h81})
            begin miscompares++; $display("FAIL hold_redir_next: got v=%0b i=%h pc=%h want 1/a0000081/81", if0.instr_valid, if0.instr, if0.instr_pc); end
    endtask

    task automatic test_reset_midstream();
        if0.stall = 1'b1;
        tick(); // HOLD on 0x81
        vectors++;
        if ({if0.instr_valid, if0.instr_pc} !== {1'b1, 32'h81})
            begin miscompares++; $display("FAIL mid_hold: got v=%0b pc=%h want 1/81", if0.instr_valid, if0.instr_pc); end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({if0.instr_valid, if0.instr, if0.instr_pc, if0.imem_addr} !== {1'b0, 32'h0, 32'h0, 12'h000})
            begin miscompares++; $display("FAIL mid_reset: got v=%0b i=%h pc=%h a=%h want 0/0/0/000", if0.instr_valid, if0.instr, if0.instr_pc, if0.imem_addr); end
        tick();
        tick();
        if0.stall = 1'b0;
        reset_n = 1'b1;
        #1;
        vectors++;
        if (if0.instr_valid !== 1'b0)
            begin miscompares++; $display("FAIL mid_restart_pre: got v=%0b want 0", if0.instr_valid); end
        tick();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({if0.instr_valid, if0.instr, if0.instr_pc} !== {1'b1, rom_word(32'(i)), 32'(i)})
                begin miscompares++; $display("FAIL mid_restart[%0d]: got v=%0b i=%h pc=%h want 1/%h/%h", i, if0.instr_valid, if0.instr, if0.instr_pc, rom_word(32'(i)), 32'(i)); end
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc   [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        logic [31:0] exp_word [4] = '{32'hA000_0FFE, 32'hA000_0FFF, 32'hA000_0000, 32'hA000_0001};
        logic [11:0] exp_addr [4] = '{12'hFFF, 12'h000, 12'h001, 12'h002};
        vectors++;
        if ({if1.instr_valid, if1.imem_addr} !== {1'b0, 12'hFFE})
            begin miscompares++; $display("FAIL wrap_reset: got v=%0b a=%h want 0/ffe", if1.instr_valid, if1.imem_addr); end
        reset_n1 = 1'b1;
        #1;
        vectors++;
        if (if1.instr_valid !== 1'b0)
            begin miscompares++; $display("FAIL wrap_pre_edge: got v=%0b want 0", if1.instr_valid); end
        tick();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({if1.instr_valid, if1.instr, if1.instr_pc, if1.imem_addr} !== {1'b1, exp_word[i], exp_pc[i], exp_addr[i]})
                begin miscompares++; $display("FAIL wrap_seq[%0d]: got v=%0b i=%h pc=%h a=%h want 1/%h/%h/%h", i, if1.instr_valid, if1.instr, if1.instr_pc, if1.imem_addr, exp_word[i], exp_pc[i], exp_addr[i]); end
            tick();
        end
    endtask

    initial begin
        reset_n1 = 1'b0;
        if1.stall = 1'b0;
        if1.redirect_valid = 1'b0;
        if1.redirect_pc = 32'h0;
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_in_hold();
        test_reset_midstream();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
